// File: rtl/mux_2x1_arbiter_pkg.sv
// Shared encodings for the 2:1 mux arbiter: FSM state constants, select polarity
// and last-owner tracking used for round-robin tie-breaks.
package mux_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_A = 2'b01;
  localparam logic [1:0] OWN_B = 2'b10;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  typedef enum logic {
    OWNER_B = 1'b0,
    OWNER_A = 1'b1
  } owner_e;

  // Hold counter width: enough to count 0..MAX_HOLD without wrapping.
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux_2x1_arbiter_if.sv
// Handshake/data bundle between two producers, the arbiter and the consumer.
// slave = arbiter side, master = producer/consumer side.
interface mux_2x1_arbiter_if #(
  parameter int WIDTH = 8
) ();

  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             select;
  logic [WIDTH-1:0] m_out;
  logic             m_valid;

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output gnt_a, gnt_b, select, m_out, m_valid
  );

  modport master (
    output req_a, req_b, data_a, data_b,
    input  gnt_a, gnt_b, select, m_out, m_valid
  );

endinterface

// File: rtl/mux_2x1_arbiter_df.sv
// Plain 2:1 dataflow mux, one generated slice per bit; sel=1 picks a.
module mux_2x1_df #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = sel ? a[i] : b[i];
  end

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter driving a shared 2:1 mux; a hold counter caps a contested
// owner at MAX_HOLD cycles while an uncontested owner keeps the channel.
module mux_2x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               reset_b,
  mux_2x1_arbiter_if.slave   bus
);

  localparam int             CW        = hold_w(MAX_HOLD);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] hold_q,  hold_d;
  owner_e        last_q,  last_d;
  logic          sel_q,   sel_d;

  logic          ra, rb, contested_end;

  assign ra            = bus.req_a;
  assign rb            = bus.req_b;
  assign contested_end = ra && rb && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ra && rb)  state_d = (last_q == OWNER_A) ? OWN_B : OWN_A;
        else if (ra)   state_d = OWN_A;
        else if (rb)   state_d = OWN_B;
      end
      OWN_A: begin
        if (!ra)               state_d = rb ? OWN_B : IDLE;
        else if (contested_end) state_d = OWN_B;
      end
      OWN_B: begin
        if (!rb)               state_d = ra ? OWN_A : IDLE;
        else if (contested_end) state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on any grant change and saturates while ownership is kept.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q)                           hold_d = '0;
    else if (state_q != IDLE && hold_q != HOLD_LAST)  hold_d = hold_q + 1'b1;
  end

  // select and last_owner only move on entry into an owning state; IDLE holds them.
  always_comb begin
    last_d = last_q;
    sel_d  = sel_q;
    if (state_d == OWN_A && state_q != OWN_A) begin
      last_d = OWNER_A;
      sel_d  = SEL_A;
    end else if (state_d == OWN_B && state_q != OWN_B) begin
      last_d = OWNER_B;
      sel_d  = SEL_B;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= OWNER_B;
      sel_q   <= SEL_B;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.gnt_a   = (state_q == OWN_A);
  assign bus.gnt_b   = (state_q == OWN_B);
  assign bus.m_valid = (state_q == OWN_A) || (state_q == OWN_B);
  assign bus.select  = sel_q;

  mux_2x1_df #(.WIDTH(WIDTH)) u_df (
    .sel (sel_q),
    .a   (bus.data_a),
    .b   (bus.data_b),
    .y   (bus.m_out)
  );

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed vector bench for mux_2x1_arbiter: MAX_HOLD=4 main instance plus a
// MAX_HOLD=1 instance for the every-cycle alternation case.
module tb_mux_2x1_arbiter;

  logic clock;
  logic reset_b;

  mux_2x1_arbiter_if #(.WIDTH(8)) if0 ();
  mux_2x1_arbiter_if #(.WIDTH(8)) if1 ();

  mux_2x1_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (if0.slave)
  );

  mux_2x1_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (if1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    assert (!(if0.gnt_a && if0.gnt_b));
    assert (!(if1.gnt_a && if1.gnt_b));
  end

  typedef struct {
    logic       rst_b;
    logic       ra;
    logic       rb;
    logic [7:0] da;
    logic [7:0] db;
    logic       ga;
    logic       gb;
    logic       sel;
    logic [7:0] mo;
    logic       mv;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst_b, logic ra, logic rb, logic [7:0] da, logic [7:0] db,
                              logic ga, logic gb, logic sel, logic [7:0] mo, logic mv);
    vec_t v;
    v.rst_b = rst_b; v.ra = ra; v.rb = rb; v.da = da; v.db = db;
    v.ga = ga; v.gb = gb; v.sel = sel; v.mo = mo; v.mv = mv;
    return v;
  endfunction

  // Drive on the falling edge, check 1 time unit after the rising edge.
  task automatic apply0(input vec_t v, input string tag, input int idx);
    logic [11:0] got, exp;
    @(negedge clock);
    reset_b    = v.rst_b;
    if0.req_a  = v.ra;
    if0.req_b  = v.rb;
    if0.data_a = v.da;
    if0.data_b = v.db;
    @(posedge clock);
    #1;
    n_vec++;
    got = {if0.gnt_a, if0.gnt_b, if0.select, if0.m_out, if0.m_valid};
    exp = {v.ga, v.gb, v.sel, v.mo, v.mv};
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: {gnt_a,gnt_b,select,m_out,m_valid} got %b_%b_%b_%h_%b want %b_%b_%b_%h_%b",
               tag, idx, got[11], got[10], got[9], got[8:1], got[0],
               exp[11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  initial begin
    reset_b    = 1'b0;
    if0.req_a  = 1'b0; if0.req_b  = 1'b0; if0.data_a = 8'hA5; if0.data_b = 8'h3C;
    if1.req_a  = 1'b0; if1.req_b  = 1'b0; if1.data_a = 8'h11; if1.data_b = 8'h22;

    // reset, then idle
    repeat (2) vq.push_back(mk(0,0,0,8'hA5,8'h3C, 0,0,0,8'h3C,0));
    repeat (5) vq.push_back(mk(1,0,0,8'hA5,8'h3C, 0,0,0,8'h3C,0));
    // uncontested A held past MAX_HOLD, then released; select holds in IDLE
    repeat (6) vq.push_back(mk(1,1,0,8'hA5,8'h3C, 1,0,1,8'hA5,1));
    vq.push_back(mk(1,0,0,8'hA5,8'h3C, 0,0,1,8'hA5,0));
    // reset to make last_owner=B, then contention: AAAA BBBB AAAA
    vq.push_back(mk(0,0,0,8'hA5,8'h3C, 0,0,0,8'h3C,0));
    repeat (4) vq.push_back(mk(1,1,1,8'hA5,8'h3C, 1,0,1,8'hA5,1));
    repeat (4) vq.push_back(mk(1,1,1,8'hA5,8'h3C, 0,1,0,8'h3C,1));
    repeat (4) vq.push_back(mk(1,1,1,8'hA5,8'h3C, 1,0,1,8'hA5,1));
    // direct handoffs A->B and B->A without an idle bubble
    vq.push_back(mk(1,0,1,8'hA5,8'h3C, 0,1,0,8'h3C,1));
    vq.push_back(mk(1,1,1,8'hA5,8'h5A, 0,1,0,8'h5A,1));
    vq.push_back(mk(1,1,0,8'hC3,8'h5A, 1,0,1,8'hC3,1));
    vq.push_back(mk(1,0,0,8'hC3,8'h5A, 0,0,1,8'hC3,0));
    // last_owner=A now, so contention from IDLE goes to B
    vq.push_back(mk(1,1,1,8'hC3,8'h5A, 0,1,0,8'h5A,1));
    vq.push_back(mk(1,0,0,8'hC3,8'h5A, 0,0,0,8'h5A,0));
    // B alone from IDLE
    vq.push_back(mk(1,0,1,8'hA5,8'h3C, 0,1,0,8'h3C,1));
    vq.push_back(mk(1,0,0,8'hA5,8'h3C, 0,0,0,8'h3C,0));

    foreach (vq[i]) apply0(vq[i], "table", i);

    // Reset while A owns with hold_cnt=2: grant drops on that edge, A wins again after.
    apply0(mk(0,1,1,8'hA5,8'h3C, 0,0,0,8'h3C,0), "midrst_pre", 0);
    for (int k = 0; k < 3; k++)
      apply0(mk(1,1,1,8'hA5,8'h3C, 1,0,1,8'hA5,1), "midrst_own", k);
    apply0(mk(0,1,1,8'hA5,8'h3C, 0,0,0,8'h3C,0), "midrst_edge", 0);
    for (int k = 0; k < 4; k++)
      apply0(mk(1,1,1,8'hA5,8'h3C, 1,0,1,8'hA5,1), "midrst_after", k);
    apply0(mk(1,1,1,8'hA5,8'h3C, 0,1,0,8'h3C,1), "midrst_preempt", 0);
    apply0(mk(0,0,0,8'hA5,8'h3C, 0,0,0,8'h3C,0), "midrst_idle", 0);

    // MAX_HOLD=1: both held high -> A, B, A, B ...
    @(negedge clock);
    reset_b   = 1'b1;
    if1.req_a = 1'b1;
    if1.req_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [10:0] got, exp;
      @(posedge clock);
      #1;
      n_vec++;
      got = {if1.gnt_a, if1.gnt_b, if1.m_out, if1.m_valid};
      exp = (k % 2 == 0) ? {1'b1, 1'b0, 8'h11, 1'b1} : {1'b0, 1'b1, 8'h22, 1'b1};
      if (got !== exp) begin
        n_err++;
        $display("FAIL hold1_alt[%0d]: {gnt_a,gnt_b,m_out,m_valid} got %b_%b_%h_%b want %b_%b_%h_%b",
                 k, got[10], got[9], got[8:1], got[0], exp[10], exp[9], exp[8:1], exp[0]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
